// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter: FU count, widths,
// the buffered result entry and the debug view of the arbiter state.
package wb_arbiter_pkg;

  localparam int FU_NUM    = 4;
  localparam int PHYS_REGS = 64;
  localparam int PHYS_W    = $clog2(PHYS_REGS);
  localparam int DW        = 32;
  localparam int EPOCH_W   = 3;
  localparam int DEPTH     = 2;
  localparam int FU_W      = $clog2(FU_NUM);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int OCC_W     = PTR_W + 1;

  typedef struct packed {
    logic [PHYS_W-1:0]  pd;
    logic [DW-1:0]      data;
    logic [EPOCH_W-1:0] epoch;
    logic               killed;
  } wb_entry_t;

  typedef struct packed {
    logic [0:0]         state;
    logic [FU_W-1:0]    lock_fu;
    logic [FU_W-1:0]    rr_ptr;
    logic [EPOCH_W-1:0] cur_epoch;
  } wb_dbg_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// FU result inputs, flush request and the PRF writeback port of wb_arbiter.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  // Handshakes (fu_valid/fu_ready, wb_valid/wb_ready): a transfer happens on a
  // clock edge where both are high; once valid is raised, its payload stays
  // stable until the transfer (wb_* may only withdraw when a flush kills it).
  logic [FU_NUM-1:0]               fu_valid;
  logic [FU_NUM-1:0]               fu_ready;
  logic [FU_NUM-1:0][PHYS_W-1:0]   fu_pd;
  logic [FU_NUM-1:0][DW-1:0]       fu_data;
  logic [FU_NUM-1:0][EPOCH_W-1:0]  fu_epoch;
  logic                            flush_valid;
  logic [EPOCH_W-1:0]              flush_epoch;
  logic                            wb_valid;
  logic                            wb_ready;
  logic [PHYS_W-1:0]               wb_pd;
  logic [DW-1:0]                   wb_data;
  logic [EPOCH_W-1:0]              wb_epoch;
  logic [FU_W-1:0]                 wb_fu;
  logic [FU_NUM-1:0][OCC_W-1:0]    occ;

  modport master (
    output fu_valid, fu_pd, fu_data, fu_epoch, flush_valid, flush_epoch, wb_ready,
    input  fu_ready, wb_valid, wb_pd, wb_data, wb_epoch, wb_fu, occ
  );

  modport slave (
    input  fu_valid, fu_pd, fu_data, fu_epoch, flush_valid, flush_epoch, wb_ready,
    output fu_ready, wb_valid, wb_pd, wb_data, wb_epoch, wb_fu, occ
  );

endinterface

// File: rtl/wb_arbiter_result_fifo.sv
// Per-FU result buffer: DEPTH entries, in-place kill of stale epochs on flush,
// head and occupancy straight from registers.
module wb_result_fifo
  import wb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  wb_entry_t          push_entry_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [EPOCH_W-1:0] flush_epoch_i,
  output wb_entry_t          head_o,
  output logic [OCC_W-1:0]   occ_o
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      occ_q;

  // Entries are never compacted; stale ones are only marked and drained at the head.
  always_comb begin
    mem_d = mem_q;
    if (flush_i) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (mem_q[e].epoch != flush_epoch_i) mem_d[e].killed = 1'b1;
      end
    end
    if (push_i) mem_d[wr_ptr_q] = push_entry_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q <= mem_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: FU_NUM result buffers feed one PRF write port,
// with a lock that holds the grant across backpressure and epoch-based squash.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus,
  output wb_dbg_t     dbg_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [FU_W-1:0]              lock_fu_q, lock_fu_d, rr_ptr_q, rr_ptr_d;
  logic [EPOCH_W-1:0]           cur_epoch_q, cur_epoch_d;
  wb_entry_t [FU_NUM-1:0]       head, push_entry;
  logic [FU_NUM-1:0]            push, pop, eligible, ready;
  logic [FU_NUM-1:0][OCC_W-1:0] occ;
  logic                         found, locked_ok, valid, xfer;
  logic [FU_W-1:0]              pick, idx, winner;

  // A result pushed during a flush is judged against the post-flush epoch.
  assign cur_epoch_d = bus.flush_valid ? bus.flush_epoch : cur_epoch_q;

  for (genvar g = 0; g < FU_NUM; g++) begin : g_fu
    assign ready[g]      = occ[g] < OCC_W'(DEPTH);
    assign push[g]       = bus.fu_valid[g] && ready[g];
    assign push_entry[g] = '{pd: bus.fu_pd[g], data: bus.fu_data[g], epoch: bus.fu_epoch[g],
                             killed: (bus.fu_epoch[g] != cur_epoch_d)};
    assign eligible[g]   = (occ[g] != '0) && !head[g].killed;
    assign pop[g]        = ((occ[g] != '0) && head[g].killed) || (xfer && (winner == FU_W'(g)));

    wb_result_fifo u_fifo (
      .clk           (clk),
      .rst           (rst),
      .push_i        (push[g]),
      .push_entry_i  (push_entry[g]),
      .pop_i         (pop[g]),
      .flush_i       (bus.flush_valid),
      .flush_epoch_i (bus.flush_epoch),
      .head_o        (head[g]),
      .occ_o         (occ[g])
    );
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      idx = FU_W'((int'(rr_ptr_q) + k) % FU_NUM);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign locked_ok = (state_q == ST_LOCK) && eligible[lock_fu_q];
  assign winner    = locked_ok ? lock_fu_q : pick;
  assign valid     = locked_ok || found;
  assign xfer      = valid && bus.wb_ready;

  always_comb begin
    state_d   = ST_IDLE;
    lock_fu_d = lock_fu_q;
    rr_ptr_d  = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (winner == FU_W'(FU_NUM - 1)) ? '0 : winner + 1'b1;
    end else if (valid && !(bus.flush_valid && (head[winner].epoch != bus.flush_epoch))) begin
      state_d   = ST_LOCK;
      lock_fu_d = winner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_fu_q   <= '0;
      rr_ptr_q    <= '0;
      cur_epoch_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_fu_q   <= lock_fu_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_epoch_q <= cur_epoch_d;
    end
  end

  assign bus.fu_ready = ready;
  assign bus.occ      = occ;
  assign bus.wb_valid = valid;
  assign bus.wb_pd    = valid ? head[winner].pd    : '0;
  assign bus.wb_data  = valid ? head[winner].data  : '0;
  assign bus.wb_epoch = valid ? head[winner].epoch : '0;
  assign bus.wb_fu    = winner;

  assign dbg_o = '{state: state_q, lock_fu: lock_fu_q, rr_ptr: rr_ptr_q, cur_epoch: cur_epoch_q};

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change on the falling edge, outputs are
// checked on the falling edge before the next inputs are applied.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  wb_dbg_t dbg;
  int      compared   = 0;
  int      mismatched = 0;

  wb_arbiter_if bus();

  wb_arbiter u_dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .dbg_o (dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.fu_valid    = '0;
    bus.fu_pd       = '0;
    bus.fu_data     = '0;
    bus.fu_epoch    = '0;
    bus.flush_valid = 1'b0;
    bus.flush_epoch = '0;
    bus.wb_ready    = 1'b0;
  endtask

  task automatic drive_fu(input int i, input logic [PHYS_W-1:0] pd, input logic [DW-1:0] data,
                          input logic [EPOCH_W-1:0] ep);
    bus.fu_valid[i] = 1'b1;
    bus.fu_pd[i]    = pd;
    bus.fu_data[i]  = data;
    bus.fu_epoch[i] = ep;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    clear_inputs();
    #1;
    check("rst_wb_valid", 64'(bus.wb_valid), 64'h0);
    check("rst_fu_ready", 64'(bus.fu_ready), 64'hF);
    check("rst_occ",      64'(bus.occ), 64'h0);
    check("rst_wb_pd",    64'(bus.wb_pd), 64'h0);
    check("rst_wb_fu",    64'(bus.wb_fu), 64'h0);
    check("rst_rr_ptr",   64'(dbg.rr_ptr), 64'h0);
    check("rst_epoch",    64'(dbg.cur_epoch), 64'h0);
    tick();
    rst = 1'b0;

    // Single push on FU2, one-cycle path to the port
    bus.wb_ready = 1'b1;
    drive_fu(2, 6'd5, 32'hDEADBEEF, 3'd0);
    tick();
    bus.fu_valid = '0;
    check("t1_wb_valid", 64'(bus.wb_valid), 64'h1);
    check("t1_wb_pd",    64'(bus.wb_pd), 64'd5);
    check("t1_wb_data",  64'(bus.wb_data), 64'hDEADBEEF);
    check("t1_wb_fu",    64'(bus.wb_fu), 64'd2);
    check("t1_occ2",     64'(bus.occ[2]), 64'd1);
    tick();
    check("t1_wb_idle",  64'(bus.wb_valid), 64'h0);
    check("t1_occ2_0",   64'(bus.occ[2]), 64'd0);
    check("t1_rr_ptr",   64'(dbg.rr_ptr), 64'd3);

    // All four FUs push together from rr_ptr=0
    reset_dut();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < FU_NUM; i++) drive_fu(i, PHYS_W'(10 + i), DW'(32'h100 + i), 3'd0);
    tick();
    bus.fu_valid = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      check($sformatf("t2_valid_%0d", k), 64'(bus.wb_valid), 64'h1);
      check($sformatf("t2_fu_%0d", k),    64'(bus.wb_fu), 64'(k));
      check($sformatf("t2_pd_%0d", k),    64'(bus.wb_pd), 64'(10 + k));
      tick();
    end
    check("t2_wb_idle", 64'(bus.wb_valid), 64'h0);
    check("t2_rr_ptr",  64'(dbg.rr_ptr), 64'd0);

    // FU1 fills its buffer under backpressure, then drains in order
    bus.wb_ready = 1'b0;
    drive_fu(1, 6'd20, 32'hA0, 3'd0);
    tick();
    check("t3_occ1_a",   64'(bus.occ[1]), 64'd1);
    check("t3_ready1_a", 64'(bus.fu_ready[1]), 64'h1);
    check("t3_pd_a",     64'(bus.wb_pd), 64'd20);
    drive_fu(1, 6'd21, 32'hA1, 3'd0);
    tick();
    check("t3_occ1_b",   64'(bus.occ[1]), 64'd2);
    check("t3_ready1_b", 64'(bus.fu_ready[1]), 64'h0);
    check("t3_pd_b",     64'(bus.wb_pd), 64'd20);
    drive_fu(1, 6'd22, 32'hA2, 3'd0);
    tick();
    check("t3_occ1_c",   64'(bus.occ[1]), 64'd2);
    check("t3_pd_c",     64'(bus.wb_pd), 64'd20);
    check("t3_data_c",   64'(bus.wb_data), 64'hA0);
    check("t3_locked",   64'(dbg.state), 64'h1);
    bus.wb_ready = 1'b1;
    tick();
    check("t3_pd_d",     64'(bus.wb_pd), 64'd21);
    check("t3_occ1_d",   64'(bus.occ[1]), 64'd1);
    check("t3_ready1_d", 64'(bus.fu_ready[1]), 64'h1);
    tick();
    bus.fu_valid = '0;
    check("t3_pd_e",     64'(bus.wb_pd), 64'd22);
    check("t3_data_e",   64'(bus.wb_data), 64'hA2);
    check("t3_occ1_e",   64'(bus.occ[1]), 64'd1);
    tick();
    check("t3_wb_idle",  64'(bus.wb_valid), 64'h0);
    check("t3_occ1_f",   64'(bus.occ[1]), 64'd0);

    // Flush kills the locked FU0 head; both stale entries drain silently
    bus.wb_ready = 1'b0;
    drive_fu(0, 6'd30, 32'h300, 3'd0);
    tick();
    drive_fu(0, 6'd31, 32'h301, 3'd0);
    tick();
    bus.fu_valid = '0;
    check("t4_valid_pre", 64'(bus.wb_valid), 64'h1);
    check("t4_fu_pre",    64'(bus.wb_fu), 64'd0);
    check("t4_occ0_pre",  64'(bus.occ[0]), 64'd2);
    check("t4_locked",    64'(dbg.state), 64'h1);
    bus.flush_valid = 1'b1;
    bus.flush_epoch = 3'd1;
    tick();
    bus.flush_valid = 1'b0;
    bus.wb_ready    = 1'b1;
    check("t4_valid_drop", 64'(bus.wb_valid), 64'h0);
    check("t4_unlocked",   64'(dbg.state), 64'h0);
    check("t4_epoch",      64'(dbg.cur_epoch), 64'd1);
    check("t4_occ0_a",     64'(bus.occ[0]), 64'd2);
    tick();
    check("t4_valid_a",    64'(bus.wb_valid), 64'h0);
    check("t4_occ0_b",     64'(bus.occ[0]), 64'd1);
    tick();
    check("t4_valid_b",    64'(bus.wb_valid), 64'h0);
    check("t4_occ0_c",     64'(bus.occ[0]), 64'd0);
    check("t4_rr_ptr",     64'(dbg.rr_ptr), 64'd2);

    // Flush coincident with pushes: FU3 (epoch 0) dies, FU2 (epoch 1) survives
    reset_dut();
    bus.wb_ready = 1'b1;
    drive_fu(3, 6'd40, 32'h33, 3'd0);
    drive_fu(2, 6'd41, 32'h22, 3'd1);
    bus.flush_valid = 1'b1;
    bus.flush_epoch = 3'd1;
    tick();
    bus.fu_valid    = '0;
    bus.flush_valid = 1'b0;
    check("t5_valid",  64'(bus.wb_valid), 64'h1);
    check("t5_fu",     64'(bus.wb_fu), 64'd2);
    check("t5_pd",     64'(bus.wb_pd), 64'd41);
    check("t5_epoch",  64'(bus.wb_epoch), 64'd1);
    check("t5_occ3",   64'(bus.occ[3]), 64'd1);
    tick();
    check("t5_idle",   64'(bus.wb_valid), 64'h0);
    check("t5_occ3_0", 64'(bus.occ[3]), 64'd0);
    check("t5_occ2_0", 64'(bus.occ[2]), 64'd0);
    check("t5_cur_ep", 64'(dbg.cur_epoch), 64'd1);

    // Asynchronous reset with three buffered results
    bus.wb_ready = 1'b0;
    drive_fu(0, 6'd50, 32'h600, 3'd1);
    drive_fu(1, 6'd51, 32'h601, 3'd1);
    drive_fu(2, 6'd52, 32'h602, 3'd1);
    tick();
    bus.fu_valid = '0;
    check("t6_valid_pre", 64'(bus.wb_valid), 64'h1);
    check("t6_fu_pre",    64'(bus.wb_fu), 64'd0);
    check("t6_data_pre",  64'(bus.wb_data), 64'h600);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(bus.wb_valid), 64'h0);
    check("t6_async_occ",   64'(bus.occ), 64'h0);
    check("t6_async_ready", 64'(bus.fu_ready), 64'hF);
    check("t6_async_pd",    64'(bus.wb_pd), 64'h0);
    check("t6_async_data",  64'(bus.wb_data), 64'h0);
    check("t6_async_epoch", 64'(dbg.cur_epoch), 64'h0);
    tick();
    tick();
    rst = 1'b0;
    bus.wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t6_post_valid_%0d", k), 64'(bus.wb_valid), 64'h0);
    end
    check("t6_post_occ", 64'(bus.occ), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
